// File: rtl/emergency_preempt.sv
// Siren-detector conditioner: synchronizes and debounces siren_raw, then issues one
// single-cycle emergency pulse per detected vehicle. A holdoff window follows each pulse.
module emergency_preempt #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLDOFF_CYCLES  = 8,
    parameter int EVT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             siren_raw,
    output logic             emergency,
    output logic             active,
    output logic             holdoff,
    output logic [EVT_W-1:0] evt_count
);

    // Both parameters are legal up to 255, so one counter width covers either.
    localparam int CW = $clog2(255 + 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PULSE    = 2'd1,
        ST_HOLDOFF  = 2'd2,
        ST_WAIT_LOW = 2'd3
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            s1;
    logic            s2;
    logic            deb_level;
    logic            deb_prev;
    logic            deb_rise;
    logic [CW-1:0]   mis_cnt;
    logic [CW-1:0]   hold_cnt;

    assign deb_rise = deb_level & ~deb_prev;
    assign active   = deb_level;

    // Synchronizer and debouncer; deb_level only flips after a full run of disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            deb_level <= 1'b0;
            deb_prev  <= 1'b0;
            mis_cnt   <= '0;
        end else begin
            s1       <= siren_raw;
            s2       <= s1;
            deb_prev <= deb_level;
            if (s2 != deb_level) begin
                if (mis_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_level <= ~deb_level;
                    mis_cnt   <= '0;
                end else begin
                    mis_cnt <= mis_cnt + CW'(1);
                end
            end else begin
                mis_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (deb_rise) state_next = ST_PULSE;
            ST_PULSE:    state_next = ST_HOLDOFF;
            ST_HOLDOFF: begin
                if (hold_cnt == '0) state_next = deb_level ? ST_WAIT_LOW : ST_IDLE;
            end
            ST_WAIT_LOW: if (!deb_level) state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            evt_count <= '0;
            emergency <= 1'b0;
            holdoff   <= 1'b0;
        end else begin
            state     <= state_next;
            emergency <= (state_next == ST_PULSE);
            holdoff   <= (state_next == ST_HOLDOFF);
            if (state == ST_PULSE) begin
                hold_cnt <= CW'(HOLDOFF_CYCLES - 1);
                if (evt_count != {EVT_W{1'b1}}) evt_count <= evt_count + EVT_W'(1);
            end else if (state == ST_HOLDOFF && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - CW'(1);
            end
        end
    end

endmodule
